// File: rtl/sram_controller.sv
// Stalls the pipeline while a 32-bit load/store is split into two 16-bit
// accesses (low halfword, then high halfword) on an asynchronous SRAM.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [16:0] r_idx;
    logic [15:0] r_wdata_hi;
    logic [15:0] r_rd_lo;
    logic [31:0] r_rdata;
    logic [17:0] r_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_we_n;
    logic        r_oe_n;

    logic        w_req;
    logic        w_last;
    logic [16:0] w_idx;
    logic [3:0]  w_cnt_next;

    assign w_req      = rd_en | wr_en;
    assign w_idx      = 17'((address - BASE_ADDR) >> 2);
    assign w_last     = (r_cnt == LAST);
    assign w_cnt_next = r_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_wr    <= 1'b0;
            r_idx      <= '0;
            r_wdata_hi <= '0;
            r_rd_lo    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Write wins when both requests are present.
                        r_state    <= LOW;
                        r_cnt      <= '0;
                        r_is_wr    <= wr_en;
                        r_idx      <= w_idx;
                        r_wdata_hi <= write_data[31:16];
                        r_addr     <= {w_idx, 1'b0};
                        r_dq_out   <= wr_en ? write_data[15:0] : '0;
                        r_dq_oe    <= wr_en;
                        r_we_n     <= ~wr_en;
                        r_oe_n     <= wr_en;
                    end
                end
                LOW: begin
                    if (w_last) begin
                        r_state  <= HIGH;
                        r_cnt    <= '0;
                        if (!r_is_wr) r_rd_lo <= sram_dq_in;
                        r_addr   <= {r_idx, 1'b1};
                        r_dq_out <= r_is_wr ? r_wdata_hi : '0;
                        r_we_n   <= ~r_is_wr;
                    end else begin
                        r_cnt <= w_cnt_next;
                        // we_n rises for the final cycle of the phase.
                        if (w_cnt_next == LAST) r_we_n <= 1'b1;
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        r_state  <= DONE;
                        r_cnt    <= '0;
                        if (!r_is_wr) r_rdata <= {sram_dq_in, r_rd_lo};
                        r_addr   <= '0;
                        r_dq_out <= '0;
                        r_dq_oe  <= 1'b0;
                        r_we_n   <= 1'b1;
                        r_oe_n   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == LAST) r_we_n <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready       = (r_state == IDLE) ? ~w_req : (r_state == DONE);
    assign read_data   = r_rdata;
    assign sram_addr   = r_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller (WAIT_CYCLES=2, BASE_ADDR=1024) with a
// small behavioural SRAM model on the halfword bus.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES(2),
        .BASE_ADDR  (32'd1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    logic [15:0] mem [0:15];
    int          we_low_cnt = 0;

    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            we_low_cnt <= we_low_cnt + 1;
            if (sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end

    typedef struct {
        string       name;
        logic        ready;
        logic        we_n;
        logic        oe_n;
        logic        dq_oe;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        chk_dq;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] cur_rd;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32({e.name, ".ready"}, 32'(ready),      32'(e.ready));
            check32({e.name, ".we_n"},  32'(sram_we_n),  32'(e.we_n));
            check32({e.name, ".oe_n"},  32'(sram_oe_n),  32'(e.oe_n));
            check32({e.name, ".dq_oe"}, 32'(sram_dq_oe), 32'(e.dq_oe));
            check32({e.name, ".addr"},  32'(sram_addr),  32'(e.addr));
            if (e.chk_dq) check32({e.name, ".dq_out"}, 32'(sram_dq_out), 32'(e.dq));
            check32({e.name, ".read_data"}, read_data, e.rd);
        end
    end

    task automatic expect_cyc(input string name, input logic rdy, input logic we, input logic oe,
                              input logic dqoe, input logic [17:0] a, input logic [15:0] dq,
                              input logic chkdq, input logic [31:0] rd);
        exp_t e;
        e.name = name; e.ready = rdy; e.we_n = we; e.oe_n = oe; e.dq_oe = dqoe;
        e.addr = a; e.dq = dq; e.chk_dq = chkdq; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic expect_idle(input string name, input logic rdy, input logic [31:0] rd);
        expect_cyc(name, rdy, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0, 1'b1, rd);
    endtask

    // One full access: cycle 0 presents the request, cycles 1-4 are the two
    // phases, cycle 5 is DONE and cycle 6 is idle again.
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [17:0] alo, input logic [17:0] ahi,
                          input int drop_at, input logic [31:0] rd_after);
        for (int c = 0; c <= 6; c++) begin
            logic        ph;
            logic [17:0] ea;
            logic [15:0] ed;
            @(posedge clk); #1;
            if (c == 0) begin
                wr_en = wr; rd_en = rd; address = a; write_data = wd;
            end else begin
                address    = 32'hFFFF_F000 + 32'(c);
                write_data = 32'hA5A5_0000 + 32'(c);
                if (c >= drop_at) begin
                    wr_en = 1'b0; rd_en = 1'b0;
                end
            end
            ph = (c >= 1 && c <= 4);
            ea = (c == 1 || c == 2) ? alo : (c == 3 || c == 4) ? ahi : 18'h0;
            ed = !(wr && ph) ? 16'h0 : (c <= 2) ? wd[15:0] : wd[31:16];
            expect_cyc($sformatf("%s.c%0d", tag, c), (c >= 5),
                       !(wr && (c == 1 || c == 3)), !(!wr && ph), wr && ph,
                       ea, ed, wr || !ph, (c >= 5) ? rd_after : cur_rd);
        end
        cur_rd = rd_after;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        address = '0; write_data = '0; cur_rd = '0;

        @(posedge clk); #1;
        expect_idle("rst.idle", 1'b1, 32'h0);
        @(posedge clk); #1;
        wr_en = 1'b1;
        expect_idle("rst.req", 1'b0, 32'h0);
        @(posedge clk); #1;
        wr_en = 1'b0; rst = 1'b1;
        expect_idle("post_rst", 1'b1, 32'h0);

        access("wr1032",  1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 18'h00004, 18'h00005, 5, 32'h0);
        access("rd1032",  1'b0, 1'b1, 32'd1032, 32'h0,        18'h00004, 18'h00005, 5, 32'hDEADBEEF);
        access("wrrd1024",1'b1, 1'b1, 32'd1024, 32'h12345678, 18'h00000, 18'h00001, 5, 32'hDEADBEEF);
        access("rd1024",  1'b0, 1'b1, 32'd1024, 32'h0,        18'h00000, 18'h00001, 5, 32'h12345678);
        access("wr1020",  1'b1, 1'b0, 32'd1020, 32'hCAFE1234, 18'h3FFFE, 18'h3FFFF, 5, 32'h12345678);
        access("rd1023",  1'b0, 1'b1, 32'd1023, 32'h0,        18'h3FFFE, 18'h3FFFF, 5, 32'hCAFE1234);
        access("rddrop",  1'b0, 1'b1, 32'd1032, 32'h0,        18'h00004, 18'h00005, 2, 32'hDEADBEEF);

        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'h0BADF00D;
        expect_cyc("abort.c0", 1'b0, 1'b1, 1'b1, 1'b0, 18'h0, 16'h0, 1'b1, cur_rd);
        @(posedge clk); #1;
        wr_en = 1'b0; address = 32'hFFFF_FFF0;
        expect_cyc("abort.c1", 1'b0, 1'b0, 1'b1, 1'b1, 18'h00004, 16'hF00D, 1'b1, cur_rd);
        @(posedge clk); #1;
        expect_cyc("abort.c2", 1'b0, 1'b1, 1'b1, 1'b1, 18'h00004, 16'hF00D, 1'b1, cur_rd);
        @(posedge clk); #1;
        rst = 1'b0;
        snap = we_low_cnt;
        cur_rd = 32'h0;
        expect_idle("abort.c3", 1'b1, 32'h0);
        for (int c = 4; c <= 8; c++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            expect_idle($sformatf("abort.c%0d", c), 1'b1, 32'h0);
        end
        @(posedge clk); #1;
        check32("abort.no_we_pulse", 32'(we_low_cnt), 32'(snap));

        @(negedge clk); #1;
        check32("sb.drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
